fp_to_int_seq: RTL and testbench

- Sequential IEEE-754 single-precision to 32-bit integer converter; the reverse direction of the adder's fp pack path.
- Decodes an fp word and produces a signed or unsigned int32 under the adder's rounding-mode encoding, with RISC-V style saturation and flags.
- Iterative shifter behind a valid/ready handshake; sits beside the adder in the ALU.

---
 rtl/fp_to_int_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_to_int_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_seq.sv
// fp_to_int_seq
//   Sequential IEEE-754 single-precision to 32-bit integer converter.
//   An accepted operand is unpacked, aligned by an iterative shifter
//   (SHIFT_PER_CYCLE bit positions per cycle), rounded with the adder's
//   rounding-mode encoding and saturated RISC-V style.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE (and out of reset); out_valid is
//   high only in DONE and the result is held stable until out_ready is seen.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready operand handshake
//   fp_a              single-precision operand
//   r_mode            000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, else RTZ
//   is_unsigned       1: uint32 result, 0: int32 result
//   out_valid/out_ready result handshake
//   int_result        converted integer
//   invalid, inexact  exception flags
//   dbg_state         current FSM state
//
// Build option: FP2INT_EARLY_OUT_EN sends specials and zeros from UNPACK
//   straight to DONE; without it they walk SHIFT and ROUND with a zero count.

module fp_to_int_seq #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_a,
  input  logic [2:0]  r_mode,
  input  logic        is_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_result,
  output logic        invalid,
  output logic        inexact,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]  state;
  logic [31:0] a_q;
  logic [2:0]  mode_q;
  logic        uns_q;
  logic        neg_q, nan_q, sat_q, zero_q, left_q;
  logic [32:0] w_q;
  logic        g_q, s_q;
  logic [4:0]  cnt_q;

  assign in_ready  = (state == ST_IDLE) && rst_n;
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;

  // Saturation value; NaN saturates toward the positive end.
  function automatic logic [31:0] sat_val(input logic nan, input logic neg,
                                          input logic uns);
    if (uns) sat_val = (nan || !neg) ? 32'hFFFF_FFFF : 32'h0000_0000;
    else     sat_val = (nan || !neg) ? 32'h7FFF_FFFF : 32'h8000_0000;
  endfunction

  // ---------------- unpack decode (from captured operand) ----------------
  logic [7:0]  exp_f, exp_eff, rdiff;
  logic [22:0] frac_f;
  logic        u_nan, u_special, u_zero, u_left;
  logic [4:0]  u_cnt;
  logic [32:0] u_w;

  always_comb begin
    exp_f     = a_q[30:23];
    frac_f    = a_q[22:0];
    u_nan     = (exp_f == 8'hFF) && (frac_f != 23'd0);
    // exp >= 159 means e >= 32; this also covers infinity and NaN.
    u_special = (exp_f >= 8'd159);
    u_zero    = (exp_f == 8'd0) && (frac_f == 23'd0);
    u_w       = {9'd0, (exp_f != 8'd0), frac_f};
    // Subnormals share the exponent of the smallest normal (e = -126).
    exp_eff   = (exp_f == 8'd0) ? 8'd1 : exp_f;
    u_left    = (exp_f >= 8'd150);
    rdiff     = 8'd150 - exp_eff;
    u_cnt     = 5'd0;
    if (u_special || u_zero) u_cnt = 5'd0;
    else if (u_left)         u_cnt = 5'(exp_f - 8'd150);
    else                     u_cnt = (rdiff > 8'd25) ? 5'd25 : rdiff[4:0];
  end

  // ---------------- one SHIFT cycle: up to SHIFT_PER_CYCLE bit steps -------
  logic [32:0] w_nx;
  logic        g_nx, s_nx;
  logic [4:0]  cnt_nx;

  always_comb begin
    w_nx   = w_q;
    g_nx   = g_q;
    s_nx   = s_q;
    cnt_nx = cnt_q;
    for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (cnt_nx != 5'd0) begin
        if (left_q) begin
          w_nx = {w_nx[31:0], 1'b0};
        end else begin
          // The previous guard bit retires into sticky.
          s_nx = s_nx | g_nx;
          g_nx = w_nx[0];
          w_nx = {1'b0, w_nx[32:1]};
        end
        cnt_nx = cnt_nx - 5'd1;
      end
    end
  end

  // ---------------- rounding and range check ----------------
  logic        inc;
  logic [32:0] m;
  logic        range_bad;
  logic [31:0] r_res;
  logic        r_inv, r_inx;

  always_comb begin
    case (mode_q)
      3'b000:  inc = g_q & (s_q | w_q[0]);
      3'b010:  inc = neg_q & (g_q | s_q);
      3'b011:  inc = !neg_q & (g_q | s_q);
      3'b100:  inc = g_q;
      default: inc = 1'b0;
    endcase
    m = w_q + {32'd0, inc};
    if (uns_q) range_bad = (neg_q && (m != 33'd0)) || (m > 33'h0_FFFF_FFFF);
    else       range_bad = (!neg_q && (m > 33'h0_7FFF_FFFF)) ||
                           (neg_q && (m > 33'h0_8000_0000));
    r_res = neg_q ? (~m[31:0] + 32'd1) : m[31:0];
    r_inv = 1'b0;
    r_inx = g_q | s_q;
    if (sat_q || range_bad) begin
      r_res = sat_val(nan_q, neg_q, uns_q);
      r_inv = 1'b1;
      r_inx = 1'b0;
    end else if (zero_q) begin
      r_res = 32'd0;
      r_inx = 1'b0;
    end
  end

  // ---------------- FSM and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_q        <= 32'd0;
      mode_q     <= 3'd0;
      uns_q      <= 1'b0;
      neg_q      <= 1'b0;
      nan_q      <= 1'b0;
      sat_q      <= 1'b0;
      zero_q     <= 1'b0;
      left_q     <= 1'b0;
      w_q        <= 33'd0;
      g_q        <= 1'b0;
      s_q        <= 1'b0;
      cnt_q      <= 5'd0;
      int_result <= 32'd0;
      invalid    <= 1'b0;
      inexact    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= fp_a;
            mode_q <= r_mode;
            uns_q  <= is_unsigned;
            state  <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          neg_q  <= a_q[31];
          nan_q  <= u_nan;
          sat_q  <= u_special;
          zero_q <= u_zero;
          left_q <= u_left;
          w_q    <= u_w;
          g_q    <= 1'b0;
          s_q    <= 1'b0;
          cnt_q  <= u_cnt;
`ifdef FP2INT_EARLY_OUT_EN
          if (u_special || u_zero) begin
            int_result <= u_special ? sat_val(u_nan, a_q[31], uns_q) : 32'd0;
            invalid    <= u_special;
            inexact    <= 1'b0;
            state      <= ST_DONE;
          end else begin
            state <= ST_SHIFT;
          end
`else
          state <= ST_SHIFT;
`endif
        end
        ST_SHIFT: begin
          if (cnt_q == 5'd0) begin
            state <= ST_ROUND;
          end else begin
            w_q   <= w_nx;
            g_q   <= g_nx;
            s_q   <= s_nx;
            cnt_q <= cnt_nx;
          end
        end
        ST_ROUND: begin
          int_result <= r_res;
          invalid    <= r_inv;
          inexact    <= r_inx;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_seq.sv
module tb_fp_to_int_seq;

`ifdef FP2INT_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 3;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_a;
  logic [2:0]  r_mode;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_result;
  logic        invalid;
  logic        inexact;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  fp_to_int_seq #(.SHIFT_PER_CYCLE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fp_a        (fp_a),
    .r_mode      (r_mode),
    .is_unsigned (is_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .int_result  (int_result),
    .invalid     (invalid),
    .inexact     (inexact),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] fp;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input string name, input logic [31:0] fp,
                              input logic [2:0] rm, input logic uns,
                              input logic [31:0] res, input logic inv,
                              input logic inx, input int lat);
    vec_t v;
    v.name = name; v.fp = fp; v.rm = rm; v.uns = uns;
    v.res = res; v.inv = inv; v.inx = inx; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Launches one operand, waits (bounded) for the result, checks latency,
  // value and flags, then accepts it.
  task automatic run_vec(input vec_t v);
    int edges;
    logic [31:0] e;
    check({v.name, " ready"}, {31'd0, in_ready}, 32'd1);
    fp_a        = v.fp;
    r_mode      = v.rm;
    is_unsigned = v.uns;
    in_valid    = 1'b1;
    exp_q.push_back(v.res);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp_a     = 32'hDEAD_BEEF;   // must not disturb the captured operand
    r_mode   = 3'b011;
    is_unsigned = ~v.uns;
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = exp_q.pop_front();
    check({v.name, " latency"}, edges, v.lat);
    check({v.name, " result"}, int_result, e);
    check({v.name, " invalid"}, {31'd0, invalid}, {31'd0, v.inv});
    check({v.name, " inexact"}, {31'd0, inexact}, {31'd0, v.inx});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({v.name, " drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int edges;
    logic [31:0] held;

    vecs[0]  = mk("pi_rne",      32'h40490FDB, 3'b000, 1'b0, 32'h00000003, 1'b0, 1'b1, 25);
    vecs[1]  = mk("m2p5_rne",    32'hC0200000, 3'b000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 25);
    vecs[2]  = mk("m2p5_rmm",    32'hC0200000, 3'b100, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1, 25);
    vecs[3]  = mk("m2p5_rdn",    32'hC0200000, 3'b010, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1, 25);
    vecs[4]  = mk("m2p5_rup",    32'hC0200000, 3'b011, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 25);
    vecs[5]  = mk("p2_31_s",     32'h4F000000, 3'b000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 11);
    vecs[6]  = mk("p2_31_u",     32'h4F000000, 3'b000, 1'b1, 32'h80000000, 1'b0, 1'b0, 11);
    vecs[7]  = mk("qnan_s",      32'h7FC00000, 3'b000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, SPECIAL_LAT);
    vecs[8]  = mk("ninf_u",      32'hFF800000, 3'b000, 1'b1, 32'h00000000, 1'b1, 1'b0, SPECIAL_LAT);
    vecs[9]  = mk("m0p5_u_rtz",  32'hBF000000, 3'b001, 1'b1, 32'h00000000, 1'b0, 1'b1, 27);
    vecs[10] = mk("m0p5_u_rdn",  32'hBF000000, 3'b010, 1'b1, 32'h00000000, 1'b1, 1'b0, 27);
    vecs[11] = mk("negzero_u",   32'h80000000, 3'b000, 1'b1, 32'h00000000, 1'b0, 1'b0, SPECIAL_LAT);
    vecs[12] = mk("one_s",       32'h3F800000, 3'b000, 1'b0, 32'h00000001, 1'b0, 1'b0, 26);
    vecs[13] = mk("subn_rup",    32'h00000001, 3'b011, 1'b0, 32'h00000001, 1'b0, 1'b1, 28);
    vecs[14] = mk("p1p5_rne",    32'h3FC00000, 3'b000, 1'b0, 32'h00000002, 1'b0, 1'b1, 26);
    vecs[15] = mk("p2_32_u",     32'h4F800000, 3'b000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, SPECIAL_LAT);
    vecs[16] = mk("maxf_u",      32'h4F7FFFFF, 3'b001, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0, 11);
    vecs[17] = mk("m2_31_s",     32'hCF000000, 3'b000, 1'b0, 32'h80000000, 1'b0, 1'b0, 11);
    vecs[18] = mk("p2p5_mode7",  32'h40200000, 3'b111, 1'b0, 32'h00000002, 1'b0, 1'b1, 25);
    vecs[19] = mk("p0p5_rne",    32'h3F000000, 3'b000, 1'b0, 32'h00000000, 1'b0, 1'b1, 27);
    vecs[20] = mk("p0p75_rne",   32'h3F400000, 3'b000, 1'b0, 32'h00000001, 1'b0, 1'b1, 27);

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    fp_a        = 32'd0;
    r_mode      = 3'd0;
    is_unsigned = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready low",  {31'd0, in_ready},  32'd0);
    check("rst out_valid",     {31'd0, out_valid}, 32'd0);
    check("rst int_result",    int_result,         32'd0);
    check("rst flags",         {30'd0, invalid, inexact}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst in_ready high", {31'd0, in_ready},  32'd1);

    // Directed table
    for (int i = 0; i < 21; i++) run_vec(vecs[i]);

    // Back-pressure: result held while out_ready stays low
    fp_a = 32'h40490FDB; r_mode = 3'b000; is_unsigned = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("bp valid", {31'd0, out_valid}, 32'd1);
    held = 32'h00000003;
    // Offer a different operand meanwhile; it must be ignored.
    in_valid = 1'b1;
    fp_a = 32'hC0200000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp hold result", int_result, held);
      check("bp hold flags/ready/valid",
            {28'd0, invalid, inexact, in_ready, out_valid}, 32'h5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release", {30'd0, out_valid, in_ready}, 32'h1);

    // Reset in the middle of SHIFT discards the operation
    fp_a = 32'hC0200000; r_mode = 3'b000; is_unsigned = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid state shift", {29'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid rst ready low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid rst int_result", int_result, 32'd0);
    check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    check("mid rst state", {29'd0, dbg_state}, 32'd0);
    // Quiet period: no result may appear after the aborted operation.
    repeat (30) @(posedge clk);
    #1;
    check("mid rst no stray", {31'd0, out_valid}, 32'd0);

    // Recovery after reset
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
